// File: rtl/pulse_param_loader.sv
// Purpose : validates 7-byte host parameter frames (A5, ADDR, D3..D0, CHK), writes a
//           staging bank, and copies the whole bank to the active outputs on a sequence boundary.
// Latency : frame_ok/frame_err and the staged write land 1 cycle after the CHK byte;
//           active outputs update 3 cycles after a sync_in rise, or COMMIT_TIMEOUT cycles
//           after the commit request if no edge arrives.
// Backpressure: none; every rx_valid byte is consumed, and stalled frames are dropped after
//           BYTE_TIMEOUT idle cycles.
//
// Ports:
//   clk_pll, reset           200 MHz clock, synchronous active-low reset
//   rx_data/rx_valid         byte stream from the host UART receiver
//   sync_in                  asynchronous period-start marker from the sequencer
//   period..block            active parameter bank driving the sequencer
//   param_update             1-cycle pulse when the active bank is loaded
//   frame_ok/frame_err       1-cycle frame verdicts (frame_err also flags a refused commit)
//   commit_pending           a commit has been requested and has not executed yet
module pulse_param_loader #(
  parameter logic [31:0] BYTE_TIMEOUT   = 32'd2000000,
  parameter logic [31:0] COMMIT_TIMEOUT = 32'd40000000,
  parameter logic [31:0] DEF_PERIOD     = 32'd200000,
  parameter logic [31:0] DEF_WIDTH      = 32'd30,
  parameter logic [31:0] DEF_DELAY      = 32'd200
) (
  input  logic        clk_pll,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        sync_in,
  output logic [31:0] period,
  output logic [31:0] p1width,
  output logic [31:0] delay,
  output logic [31:0] p2width,
  output logic [6:0]  pre_att,
  output logic [6:0]  post_att,
  output logic [7:0]  cpmg,
  output logic [7:0]  pulse_block,
  output logic [15:0] pulse_block_off,
  output logic        pump,
  output logic        block,
  output logic        param_update,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        commit_pending
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_CHK
  } state_t;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] p1width;
    logic [31:0] delay;
    logic [31:0] p2width;
    logic [6:0]  pre_att;
    logic [6:0]  post_att;
    logic [7:0]  cpmg;
    logic [7:0]  pulse_block;
    logic [15:0] pulse_block_off;
    logic        pump;
    logic        block;
  } param_t;

  localparam param_t PARAM_RST = '{
    period:          DEF_PERIOD,
    p1width:         DEF_WIDTH,
    delay:           DEF_DELAY,
    p2width:         DEF_WIDTH,
    pre_att:         7'd127,
    post_att:        7'd127,
    cpmg:            8'd0,
    pulse_block:     8'd100,
    pulse_block_off: 16'd1000,
    pump:            1'b1,
    block:           1'b0
  };

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  xor_q, xor_d;
  logic [31:0] byte_tmr_q, byte_tmr_d;
  param_t      stg_q, stg_d;
  param_t      act_q, act_d;
  logic        commit_pending_q, commit_pending_d;
  logic [31:0] commit_tmr_q, commit_tmr_d;
  logic        param_update_q, param_update_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic        sync_meta_q, sync_meta_d;
  logic        sync_sync_q, sync_sync_d;
  logic        sync_prev_q, sync_prev_d;

  logic        commit_req;
  logic        sync_rise;
  logic        commit_fire;

  always_comb begin
    state_d          = state_q;
    byte_cnt_d       = byte_cnt_q;
    addr_d           = addr_q;
    data_d           = data_q;
    xor_d            = xor_q;
    byte_tmr_d       = byte_tmr_q;
    stg_d            = stg_q;
    act_d            = act_q;
    commit_pending_d = commit_pending_q;
    commit_tmr_d     = commit_tmr_q;
    param_update_d   = 1'b0;
    frame_ok_d       = 1'b0;
    frame_err_d      = 1'b0;
    commit_req       = 1'b0;

    sync_meta_d = sync_in;
    sync_sync_d = sync_meta_q;
    sync_prev_d = sync_sync_q;
    sync_rise   = sync_sync_q & ~sync_prev_q;

    // Inter-byte timer only runs while a frame is open.
    if (rx_valid || (state_q == ST_IDLE)) begin
      byte_tmr_d = '0;
    end else begin
      byte_tmr_d = byte_tmr_q + 32'd1;
    end

    if (rx_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_data == HDR_BYTE) begin
            state_d = ST_ADDR;
          end
        end
        ST_ADDR: begin
          addr_d     = rx_data;
          xor_d      = rx_data;
          byte_cnt_d = 2'd0;
          state_d    = ST_DATA;
        end
        ST_DATA: begin
          data_d     = {data_q[23:0], rx_data};
          xor_d      = xor_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = ST_CHK;
          end
        end
        ST_CHK: begin
          state_d = ST_IDLE;
          if (rx_data != xor_q) begin
            frame_err_d = 1'b1;
          end else begin
            frame_ok_d = 1'b1;
            case (addr_q)
              8'h00:   stg_d.period          = data_q;
              8'h01:   stg_d.p1width         = data_q;
              8'h02:   stg_d.delay           = data_q;
              8'h03:   stg_d.p2width         = data_q;
              8'h04:   stg_d.pre_att         = data_q[6:0];
              8'h05:   stg_d.post_att        = data_q[6:0];
              8'h06:   stg_d.cpmg            = data_q[7:0];
              8'h07:   stg_d.pulse_block     = data_q[7:0];
              8'h08:   stg_d.pulse_block_off = data_q[15:0];
              8'h09: begin
                stg_d.pump  = data_q[0];
                stg_d.block = data_q[1];
              end
              8'h0F:   commit_req = 1'b1;
              default: begin
                frame_ok_d  = 1'b0;
                frame_err_d = 1'b1;
              end
            endcase
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if ((state_q != ST_IDLE) && (byte_tmr_q >= BYTE_TIMEOUT)) begin
      frame_err_d = 1'b1;
      state_d     = ST_IDLE;
    end

    // Commit copies stg_q, not stg_d: a write landing in the same cycle stays
    // staged for the next commit instead of leaking into this one.
    commit_fire = commit_pending_q &&
                  (sync_rise || ((commit_tmr_q + 32'd1) >= COMMIT_TIMEOUT));

    if (commit_pending_q) begin
      commit_tmr_d = commit_tmr_q + 32'd1;
    end else begin
      commit_tmr_d = '0;
    end

    if (commit_fire) begin
      commit_pending_d = 1'b0;
      commit_tmr_d     = '0;
      if (stg_q.period == 32'd0) begin
        // A zero period would stall the sequencer; refuse the whole bank.
        frame_err_d = 1'b1;
      end else begin
        act_d          = stg_q;
        param_update_d = 1'b1;
      end
    end else if (commit_req) begin
      // Repeat requests while pending leave the running timer untouched.
      commit_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      byte_cnt_q       <= '0;
      addr_q           <= '0;
      data_q           <= '0;
      xor_q            <= '0;
      byte_tmr_q       <= '0;
      stg_q            <= PARAM_RST;
      act_q            <= PARAM_RST;
      commit_pending_q <= 1'b0;
      commit_tmr_q     <= '0;
      param_update_q   <= 1'b0;
      frame_ok_q       <= 1'b0;
      frame_err_q      <= 1'b0;
      sync_meta_q      <= 1'b0;
      sync_sync_q      <= 1'b0;
      sync_prev_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      byte_cnt_q       <= byte_cnt_d;
      addr_q           <= addr_d;
      data_q           <= data_d;
      xor_q            <= xor_d;
      byte_tmr_q       <= byte_tmr_d;
      stg_q            <= stg_d;
      act_q            <= act_d;
      commit_pending_q <= commit_pending_d;
      commit_tmr_q     <= commit_tmr_d;
      param_update_q   <= param_update_d;
      frame_ok_q       <= frame_ok_d;
      frame_err_q      <= frame_err_d;
      sync_meta_q      <= sync_meta_d;
      sync_sync_q      <= sync_sync_d;
      sync_prev_q      <= sync_prev_d;
    end
  end

  assign period          = act_q.period;
  assign p1width         = act_q.p1width;
  assign delay           = act_q.delay;
  assign p2width         = act_q.p2width;
  assign pre_att         = act_q.pre_att;
  assign post_att        = act_q.post_att;
  assign cpmg            = act_q.cpmg;
  assign pulse_block     = act_q.pulse_block;
  assign pulse_block_off = act_q.pulse_block_off;
  assign pump            = act_q.pump;
  assign block           = act_q.block;
  assign param_update    = param_update_q;
  assign frame_ok        = frame_ok_q;
  assign frame_err       = frame_err_q;
  assign commit_pending  = commit_pending_q;

endmodule

// File: tb/tb_pulse_param_loader.sv
// Purpose : directed and randomized frame traffic against pulse_param_loader, checked
//           against a register-array model of the staging and active banks.
// Latency : the model applies writes after the CHK byte and commits 3 cycles after a sync rise.
// Backpressure: not applicable; the bench paces bytes itself.
`timescale 1ns/1ps
module tb_pulse_param_loader;

  localparam logic [31:0] BTO = 32'd50;
  localparam logic [31:0] CTO = 32'd1000;

  logic        clk_pll = 1'b0;
  logic        reset   = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        sync_in  = 1'b0;
  logic [31:0] period, p1width, delay, p2width;
  logic [6:0]  pre_att, post_att;
  logic [7:0]  cpmg, pulse_block;
  logic [15:0] pulse_block_off;
  logic        pump, block, param_update, frame_ok, frame_err, commit_pending;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: index = register address 0x00..0x09.
  logic [31:0] m_stg [0:9];
  logic [31:0] m_act [0:9];
  bit          m_pend;

  pulse_param_loader #(
    .BYTE_TIMEOUT  (BTO),
    .COMMIT_TIMEOUT(CTO)
  ) dut (
    .clk_pll        (clk_pll),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .sync_in        (sync_in),
    .period         (period),
    .p1width        (p1width),
    .delay          (delay),
    .p2width        (p2width),
    .pre_att        (pre_att),
    .post_att       (post_att),
    .cpmg           (cpmg),
    .pulse_block    (pulse_block),
    .pulse_block_off(pulse_block_off),
    .pump           (pump),
    .block          (block),
    .param_update   (param_update),
    .frame_ok       (frame_ok),
    .frame_err      (frame_err),
    .commit_pending (commit_pending)
  );

  always #5 clk_pll = ~clk_pll;
  always @(posedge clk_pll) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (n_tests=%0d)", n_tests);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mask_of(input int a);
    case (a)
      0, 1, 2, 3: return 32'hFFFF_FFFF;
      4, 5:       return 32'h0000_007F;
      6, 7:       return 32'h0000_00FF;
      8:          return 32'h0000_FFFF;
      9:          return 32'h0000_0003;
      default:    return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_stg[0] = 32'd200000; m_stg[1] = 32'd30;  m_stg[2] = 32'd200;
    m_stg[3] = 32'd30;     m_stg[4] = 32'd127; m_stg[5] = 32'd127;
    m_stg[6] = 32'd0;      m_stg[7] = 32'd100; m_stg[8] = 32'd1000;
    m_stg[9] = 32'd1;      // pump=1, block=0
    for (int i = 0; i < 10; i++) m_act[i] = m_stg[i];
    m_pend = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic check_act(input string tag);
    chk({tag, ".period"},          period,          m_act[0]);
    chk({tag, ".p1width"},         p1width,         m_act[1]);
    chk({tag, ".delay"},           delay,           m_act[2]);
    chk({tag, ".p2width"},         p2width,         m_act[3]);
    chk({tag, ".pre_att"},         pre_att,         m_act[4]);
    chk({tag, ".post_att"},        post_att,        m_act[5]);
    chk({tag, ".cpmg"},            cpmg,            m_act[6]);
    chk({tag, ".pulse_block"},     pulse_block,     m_act[7]);
    chk({tag, ".pulse_block_off"}, pulse_block_off, m_act[8]);
    chk({tag, ".pump"},            pump,            m_act[9][0]);
    chk({tag, ".block"},           block,           m_act[9][1]);
  endtask

  task automatic step();
    @(posedge clk_pll);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Sends one frame; chk_flip XORs into the correct checksum (0 = good frame).
  task automatic send_frame(input logic [7:0] a, input logic [31:0] d,
                            input logic [7:0] chk_flip, input int gap);
    logic [7:0] bytes [0:6];
    bit good;
    bytes[0] = 8'hA5; bytes[1] = a;
    bytes[2] = d[31:24]; bytes[3] = d[23:16]; bytes[4] = d[15:8]; bytes[5] = d[7:0];
    bytes[6] = (a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0]) ^ chk_flip;
    for (int i = 0; i < 7; i++) begin
      if (gap > 0) repeat ($urandom_range(0, gap)) step();
      send_byte(bytes[i]);
    end
    good = (chk_flip == 8'h00) && ((a <= 8'h09) || (a == 8'h0F));
    chk("frame_ok", frame_ok, good);
    chk("frame_err", frame_err, !good);
    if (good) begin
      if (a == 8'h0F) m_pend = 1'b1;
      else            m_stg[a] = d & mask_of(int'(a));
    end
    chk("commit_pending", commit_pending, m_pend);
  endtask

  // Raises sync_in and checks the commit three cycles later.
  task automatic sync_commit();
    bit exp_ok;
    sync_in = 1'b1;
    step();
    step();
    chk("update_early", param_update, 1'b0);
    step();
    exp_ok = (m_stg[0] != 32'd0);
    chk("param_update", param_update, exp_ok);
    chk("commit_err", frame_err, !exp_ok);
    if (exp_ok) for (int i = 0; i < 10; i++) m_act[i] = m_stg[i];
    m_pend = 1'b0;
    chk("pending_clear", commit_pending, 1'b0);
    check_act("commit");
    sync_in = 1'b0;
    step();
    chk("update_one_cycle", param_update, 1'b0);
    step();
    step();
  endtask

  initial begin
    bit          seen;
    bit          early;
    int          k, t0, diff;
    logic [7:0]  a, c, g;
    logic [31:0] d;
    int          r;

    // Reset state
    model_reset();
    repeat (3) step();
    check_act("reset");
    chk("reset.param_update", param_update, 1'b0);
    chk("reset.frame_ok", frame_ok, 1'b0);
    chk("reset.frame_err", frame_err, 1'b0);
    chk("reset.commit_pending", commit_pending, 1'b0);
    reset = 1'b1;
    step();

    // Period staged, held until the sync edge
    send_frame(8'h00, 32'd20000, 8'h00, 0);
    check_act("staged_only");
    send_frame(8'h0F, 32'd0, 8'h00, 0);
    check_act("pending_no_edge");
    sync_commit();
    chk("period_20000", period, 32'd20000);

    // Attenuator staged then committed
    send_frame(8'h04, 32'h1F, 8'h00, 0);
    chk("pre_att_held", pre_att, 7'd127);
    send_frame(8'h0F, 32'd0, 8'h00, 0);
    sync_commit();
    chk("pre_att_31", pre_att, 7'd31);

    // Corrupted checksum: A5 01 00 00 00 10 00
    send_frame(8'h01, 32'h10, 8'h11, 0);
    send_frame(8'h0F, 32'd0, 8'h00, 0);
    sync_commit();
    chk("p1width_kept", p1width, 32'd30);

    // Unmapped address and non-header bytes in IDLE
    send_frame(8'h0A, 32'd5, 8'h00, 0);
    send_byte(8'h00); chk("idle_ignore0", frame_err, 1'b0);
    send_byte(8'h5A); chk("idle_ignore1", frame_err, 1'b0);
    send_byte(8'hFF); chk("idle_ignore2", frame_err, 1'b0);

    // Byte timeout mid-frame, then a good frame
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    seen = 1'b0; k = 0;
    while (!seen && k < int'(BTO) + 20) begin
      step(); k++;
      if (frame_err) seen = 1'b1;
    end
    chk("byte_timeout_seen", seen, 1'b1);
    chk("byte_timeout_window", (k >= int'(BTO)) && (k <= int'(BTO) + 2), 1'b1);
    send_frame(8'h02, 32'd777, 8'h00, 1);

    // Commit by timeout with sync_in low; a repeat request does not restart the timer
    send_frame(8'h03, 32'd4321, 8'h00, 0);
    send_frame(8'h0F, 32'd0, 8'h00, 0);
    t0 = cyc;
    early = 1'b0;
    repeat (400) begin
      step();
      if (param_update) early = 1'b1;
    end
    send_frame(8'h0F, 32'd0, 8'h00, 0);
    seen = 1'b0; k = 0;
    while (!seen && k < 2000) begin
      if (param_update) seen = 1'b1;
      else begin step(); k++; end
    end
    diff = cyc - t0;
    chk("timeout_no_early", early, 1'b0);
    chk("timeout_seen", seen, 1'b1);
    chk("timeout_latency", diff, CTO);
    for (int i = 0; i < 10; i++) m_act[i] = m_stg[i];
    m_pend = 1'b0;
    chk("timeout_pending_clear", commit_pending, 1'b0);
    check_act("timeout_commit");
    step();

    // Staged write landing on the commit edge stays staged
    send_frame(8'h02, 32'd1111, 8'h00, 0);
    send_frame(8'h0F, 32'd0, 8'h00, 0);
    d = 32'd2222;
    c = 8'h02 ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(d[31:24]); send_byte(d[23:16]); send_byte(d[15:8]); send_byte(d[7:0]);
    sync_in = 1'b1;
    step();
    step();
    send_byte(c);
    chk("collide.param_update", param_update, 1'b1);
    chk("collide.frame_ok", frame_ok, 1'b1);
    for (int i = 0; i < 10; i++) m_act[i] = m_stg[i];
    m_stg[2] = d;
    m_pend = 1'b0;
    chk("collide.delay_old", delay, 32'd1111);
    check_act("collide");
    sync_in = 1'b0;
    repeat (3) step();
    send_frame(8'h0F, 32'd0, 8'h00, 0);
    sync_commit();
    chk("collide.delay_new", delay, 32'd2222);

    // Zero period refuses the commit
    send_frame(8'h00, 32'd0, 8'h00, 0);
    send_frame(8'h0F, 32'd0, 8'h00, 0);
    sync_commit();
    chk("zero_period_kept", period, 32'd20000);
    send_frame(8'h00, 32'd12345, 8'h00, 0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 12);
      if (r <= 9)       a = 8'(r);
      else if (r == 10) a = 8'h0B;
      else if (r == 11) a = 8'h0E;
      else              a = 8'h3C;
      d = $urandom;
      c = ($urandom_range(0, 4) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      if ($urandom_range(0, 3) == 0) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send_byte(g);
        chk("rand_idle_byte", frame_err, 1'b0);
      end
      send_frame(a, d, c, 3);
      if ($urandom_range(0, 3) == 0) begin
        send_frame(8'h0F, $urandom, 8'h00, 2);
        sync_commit();
      end
    end
    send_frame(8'h0F, 32'd0, 8'h00, 0);
    sync_commit();

    // Reset mid-frame with a commit pending
    send_frame(8'h01, 32'd999, 8'h00, 0);
    send_frame(8'h0F, 32'd0, 8'h00, 0);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    model_reset();
    step();
    chk("midreset.pending", commit_pending, 1'b0);
    check_act("midreset");
    send_byte(8'h00); send_byte(8'h00);
    chk("midreset.leftover", frame_err, 1'b0);
    send_frame(8'h0F, 32'd0, 8'h00, 0);
    sync_commit();
    chk("midreset.p1width", p1width, 32'd30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_param_loader.md
Name: pulse_param_loader

Overview:
- Upstream of the pulse sequencer: receives LabView parameter frames as a byte stream from the host UART receiver.
- Validates each frame and writes the value into a staging register bank.
- Transfers the staged bank to the active outputs only on a sequence boundary, so the sequencer never sees a half-updated parameter set mid-period.
- Active outputs drive the sequencer's period/width/delay/attenuator/mode/block inputs directly.

Parameters:
- BYTE_TIMEOUT, 32'd2000000, idle cycles allowed between bytes of one frame (10 ms at 200 MHz).
- COMMIT_TIMEOUT, 32'd40000000, cycles to wait for a sync edge before forcing a pending commit (200 ms).
- DEF_PERIOD, 32'd200000, reset value of period.
- DEF_WIDTH, 32'd30, reset value of p1width and p2width.
- DEF_DELAY, 32'd200, reset value of delay.

Ports:
- clk_pll  in  1  200 MHz PLL clock.
- reset  in  1  reset, synchronous, active-low; clock clk_pll.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- sync_in  in  1  scope trigger from the sequencer; its rising edge marks a period start.
- period, p1width, delay, p2width  out  32 each  active timing values.
- pre_att, post_att  out  7 each  active attenuator codes.
- cpmg  out  8  active mode (0 = CW).
- pulse_block  out  8  active value.
- pulse_block_off  out  16  active value.
- pump, block  out  1 each  active flags.
- param_update  out  1  one-cycle pulse when the active bank is loaded.
- frame_ok  out  1  one-cycle pulse when a frame is accepted.
- frame_err  out  1  one-cycle pulse when a frame is rejected.
- commit_pending  out  1  high from a commit request until the commit executes.

Behaviour:
- Frame format, 7 bytes: 0xA5 header, ADDR, D3, D2, D1, D0 (MSB first), CHK.
  - CHK = ADDR^D3^D2^D1^D0.
- FSM states: IDLE, ADDR, DATA (4-byte counter), CHK.
  - IDLE: a byte equal to 0xA5 goes to ADDR; any other byte is ignored with no error.
  - ADDR: capture the address byte and go to DATA.
  - DATA: shift each byte into a 32-bit register; after the 4th byte go to CHK.
  - CHK: compare against the running XOR, then return to IDLE.
- Byte timeout: a counter resets on every rx_valid. If it reaches BYTE_TIMEOUT in any state other than IDLE, pulse frame_err and go to IDLE.
- On a good checksum, write the staging register for ADDR, truncated to the register's width (low bits kept):
  - 0x00 period, 0x01 p1width, 0x02 delay, 0x03 p2width
  - 0x04 pre_att, 0x05 post_att, 0x06 cpmg
  - 0x07 pulse_block, 0x08 pulse_block_off
  - 0x09 flags: bit0 = pump, bit1 = block
  - 0x0F commit request: sets commit_pending; data is ignored.
  - The write happens in the cycle after the CHK byte, together with the frame_ok pulse.
- Bad checksum or unmapped ADDR: frame_err pulse, no register change.
- Commit:
  - While commit_pending=1, the first sync_in rising edge copies all staging registers to the outputs on the next clock edge.
  - The same edge clears commit_pending and pulses param_update for 1 cycle.
  - sync_in passes through a 2-flop synchronizer plus edge detect: 3 cycles from the sync_in rise to updated outputs.
  - Timeout: a commit timer counts while commit_pending=1. If it reaches COMMIT_TIMEOUT with no edge, commit immediately. This covers CW mode, where sync timing differs.
  - A staged write must not be lost: if it lands in the same cycle as a commit, the commit takes the pre-write staged value and the new value stays staged.
  - A second commit request while one is pending is a no-op; the timer is not restarted.
  - Staged period of 0: the commit is refused, frame_err pulses, commit_pending clears, and the outputs are unchanged.
- Reset (reset=0 at a clk_pll edge):
  - FSM to IDLE; all timers cleared.
  - Staging and active registers: period=DEF_PERIOD, p1width=p2width=DEF_WIDTH, delay=DEF_DELAY, pre_att=post_att=7'd127, cpmg=0, pulse_block=8'd100, pulse_block_off=16'd1000, pump=1, block=0.
  - param_update=frame_ok=frame_err=commit_pending=0.
  - A reset mid-frame discards the partial frame; a pending commit is dropped.

Test Plan:
- Send A5 00 00 00 4E 20 6E, then A5 0F 00 00 00 00 0F, then a sync_in rise -> period stays 200000 until the edge; 3 cycles later period=20000 with a one-cycle param_update pulse.
- Send A5 04 00 00 00 1F 1B -> frame_ok; pre_att output stays 127; after commit, pre_att=31.
- Send a frame with a corrupted CHK (A5 01 00 00 00 10 00) -> frame_err pulse; p1width staging stays 30.
- Send A5 02 00, then hold off for BYTE_TIMEOUT cycles -> frame_err. A following valid frame is accepted.
- Issue a commit request with sync_in held low -> commit fires exactly COMMIT_TIMEOUT cycles later (bench overrides the parameter to 1000).
- Stage period=0, then request a commit -> frame_err; period remains at its prior value; commit_pending=0.
